// File: rtl/deser_pkg.sv
// Shared constants and types for the 2-bit-symbol to 16-bit-word deserializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package deser_pkg;

    localparam int SYM_W         = 2;
    localparam int WORD_W        = 16;
    localparam int SYMS_PER_WORD = WORD_W / SYM_W;
    // Width of the per-word symbol counter (counts 0 .. SYMS_PER_WORD-1).
    localparam int SYM_CNT_W     = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/deser_fifo.sv
// Small synchronous FIFO buffering reassembled words for the output handshake.
// Latency: a pushed word is visible on head the cycle after the push edge.
// Backpressure: exposes full; a push while full is accepted only with a same-cycle pop.
//
// Ports: clk, rst (async active-high), clear (sync flush), push/din, pop,
//        full, empty, head (oldest entry, valid when !empty).
module deser_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/deserializer.sv
// Reassembles MSB-first serial symbols into words, buffered onto a valid/ready output.
// Latency: m_valid rises the cycle after the edge capturing a word's last symbol (buffer empty).
// Backpressure: none on the serial side; a completed word hitting a full buffer is dropped and flagged.
//
// Ports: clk, rst (async active-high), clear (sync flush/realign),
//        s_in/s_valid (serial symbols), m_data/m_valid/m_ready (word output),
//        word_lost, frame_err (one-cycle pulses), overflow_sticky, busy.
// Optional: define DESER_STATS_EN to add word_cnt/drop_cnt saturating counters.
module deserializer
    import deser_pkg::*;
#(
    parameter int SYM_W       = deser_pkg::SYM_W,
    parameter int WORD_W      = deser_pkg::WORD_W,
    parameter int FIFO_DEPTH  = 2,
    parameter int GAP_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [SYM_W-1:0]  s_in,
    input  logic              s_valid,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              word_lost,
    output logic              frame_err,
    output logic              overflow_sticky,
    output logic              busy
`ifdef DESER_STATS_EN
    ,
    output logic [15:0]       word_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int N     = WORD_W / SYM_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int GAP_W = (GAP_TIMEOUT < 2) ? 1 : $clog2(GAP_TIMEOUT + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [GAP_W-1:0]   gap, gap_n;
    logic [WORD_W-1:0]  sreg, sreg_n;
    logic [WORD_W-1:0]  word;
    logic               push;
    logic               timeout;
    logic               pop;
    logic               lost;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_head;

    // The completed word includes the symbol arriving on this edge.
    assign word = {sreg[WORD_W-SYM_W-1:0], s_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            gap   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            gap   <= gap_n;
            sreg  <= sreg_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gap_n   = gap;
        sreg_n  = sreg;
        push    = 1'b0;
        timeout = 1'b0;
        if (clear) begin
            // Realign: symbols presented during clear are ignored.
            state_n = IDLE;
            cnt_n   = '0;
            gap_n   = '0;
        end else if (s_valid) begin
            sreg_n = word;
            gap_n  = '0;
            if (cnt == CNT_W'(N - 1)) begin
                push    = 1'b1;
                cnt_n   = '0;
                state_n = IDLE;
            end else begin
                cnt_n   = cnt + 1'b1;
                state_n = COLLECT;
            end
        end else if (state == COLLECT && GAP_TIMEOUT != 0) begin
            if (gap == GAP_W'(GAP_TIMEOUT - 1)) begin
                timeout = 1'b1;
                cnt_n   = '0;
                gap_n   = '0;
                state_n = IDLE;
            end else begin
                gap_n = gap + 1'b1;
            end
        end
    end

    assign pop  = m_valid && m_ready;
    // A simultaneous pop frees the slot, so only an unaided full push is lost.
    assign lost = push && fifo_full && !pop;

    deser_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .din   (word),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_head : '0;
    assign busy    = (state == COLLECT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_lost       <= 1'b0;
            frame_err       <= 1'b0;
            overflow_sticky <= 1'b0;
        end else begin
            word_lost <= lost;
            frame_err <= timeout;
            if (clear)     overflow_sticky <= 1'b0;
            else if (lost) overflow_sticky <= 1'b1;
        end
    end

`ifdef DESER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            drop_cnt <= '0;
        end else if (clear) begin
            word_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push && !lost && word_cnt != 16'hFFFF)
                word_cnt <= word_cnt + 1'b1;
            if ((lost || timeout) && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: reset, reassembly, back-to-back, overflow,
// gap timeout, reset mid-word, and simultaneous push/pop while full.
module tb_deserializer;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [1:0]  s_in;
    logic        s_valid;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        word_lost;
    logic        frame_err;
    logic        overflow_sticky;
    logic        busy;

    int compared;
    int mismatched;
    int lost_pulses;
    int frame_pulses;

    deserializer dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .s_in            (s_in),
        .s_valid         (s_valid),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .word_lost       (word_lost),
        .frame_err       (frame_err),
        .overflow_sticky (overflow_sticky),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && word_lost) lost_pulses++;
        if (!rst && frame_err) frame_pulses++;
    end

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Send the first n symbols of w, MSB-first, one per cycle.
    task automatic send_part(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            s_in    = w[2*(7-i) +: 2];
            s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; s_in = 2'b00; s_valid = 1'b0; m_ready = 1'b0;
        #3;
        compared++;
        if ({m_valid, m_data, word_lost, frame_err, overflow_sticky, busy} !== 21'd0) begin
            $display("FAIL reset_outputs got v=%b d=%h wl=%b fe=%b st=%b busy=%b exp all 0",
                     m_valid, m_data, word_lost, frame_err, overflow_sticky, busy);
            mismatched++;
        end
        step(); step();
        rst = 1'b0;
        step();
        compared++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL post_reset_idle got v=%b busy=%b exp 0 0", m_valid, busy);
            mismatched++;
        end
    endtask

    task automatic test_reassembly();
        logic [15:0] w;
        int bad;
        w = 16'hABCD;
        m_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            s_in = w[2*(7-i) +: 2];
            s_valid = 1'b1;
            step();
            if (i < 7 && (busy !== 1'b1 || m_valid !== 1'b0)) bad++;
        end
        s_valid = 1'b0;
        compared++;
        if (bad != 0) begin
            $display("FAIL reasm_busy got %0d bad symbol cycles exp 0", bad);
            mismatched++;
        end
        compared++;
        if (m_valid !== 1'b1 || m_data !== 16'hABCD || busy !== 1'b0) begin
            $display("FAIL reasm_word got v=%b d=%h busy=%b exp 1 abcd 0", m_valid, m_data, busy);
            mismatched++;
        end
        step();
        compared++;
        if (m_valid !== 1'b0) begin
            $display("FAIL reasm_one_cycle got v=%b exp 0", m_valid);
            mismatched++;
        end
    endtask

    task automatic test_back_to_back();
        int lost0;
        lost0 = lost_pulses;
        m_ready = 1'b1;
        send_part(16'hABCD, 8);
        compared++;
        if (m_valid !== 1'b1 || m_data !== 16'hABCD) begin
            $display("FAIL b2b_first got v=%b d=%h exp 1 abcd", m_valid, m_data);
            mismatched++;
        end
        send_part(16'h1234, 8);
        compared++;
        if (m_valid !== 1'b1 || m_data !== 16'h1234) begin
            $display("FAIL b2b_second got v=%b d=%h exp 1 1234", m_valid, m_data);
            mismatched++;
        end
        idle(2);
        compared++;
        if (lost_pulses != lost0 || m_valid !== 1'b0) begin
            $display("FAIL b2b_no_loss got lost=%0d v=%b exp 0 0", lost_pulses - lost0, m_valid);
            mismatched++;
        end
    endtask

    task automatic test_overflow();
        int lost0;
        lost0 = lost_pulses;
        m_ready = 1'b0;
        send_part(16'hABCD, 8);
        send_part(16'h1234, 8);
        compared++;
        if (word_lost !== 1'b0 || overflow_sticky !== 1'b0) begin
            $display("FAIL ovf_two_fit got wl=%b st=%b exp 0 0", word_lost, overflow_sticky);
            mismatched++;
        end
        send_part(16'h5A5A, 8);
        compared++;
        if (word_lost !== 1'b1 || overflow_sticky !== 1'b1 || m_data !== 16'hABCD) begin
            $display("FAIL ovf_third got wl=%b st=%b d=%h exp 1 1 abcd", word_lost, overflow_sticky, m_data);
            mismatched++;
        end
        idle(1);
        compared++;
        if (word_lost !== 1'b0 || overflow_sticky !== 1'b1 || lost_pulses - lost0 != 1) begin
            $display("FAIL ovf_pulse got wl=%b st=%b pulses=%0d exp 0 1 1",
                     word_lost, overflow_sticky, lost_pulses - lost0);
            mismatched++;
        end
        m_ready = 1'b1;
        step();
        compared++;
        if (m_valid !== 1'b1 || m_data !== 16'h1234) begin
            $display("FAIL ovf_drain got v=%b d=%h exp 1 1234", m_valid, m_data);
            mismatched++;
        end
        step();
        compared++;
        if (m_valid !== 1'b0) begin
            $display("FAIL ovf_empty got v=%b exp 0", m_valid);
            mismatched++;
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        compared++;
        if (overflow_sticky !== 1'b0) begin
            $display("FAIL ovf_clear got st=%b exp 0", overflow_sticky);
            mismatched++;
        end
    endtask

    task automatic test_gap();
        int fe0;
        fe0 = frame_pulses;
        m_ready = 1'b1;
        send_part(16'hFFFF, 3);
        idle(3);
        compared++;
        if (busy !== 1'b1 || frame_err !== 1'b0) begin
            $display("FAIL gap_hold got busy=%b fe=%b exp 1 0", busy, frame_err);
            mismatched++;
        end
        idle(1);
        compared++;
        if (busy !== 1'b0 || frame_err !== 1'b1) begin
            $display("FAIL gap_timeout got busy=%b fe=%b exp 0 1", busy, frame_err);
            mismatched++;
        end
        idle(1);
        compared++;
        if (frame_err !== 1'b0 || frame_pulses - fe0 != 1) begin
            $display("FAIL gap_pulse got fe=%b pulses=%0d exp 0 1", frame_err, frame_pulses - fe0);
            mismatched++;
        end
        send_part(16'h5A5A, 8);
        compared++;
        if (m_valid !== 1'b1 || m_data !== 16'h5A5A) begin
            $display("FAIL gap_realign got v=%b d=%h exp 1 5a5a", m_valid, m_data);
            mismatched++;
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        send_part(16'h1234, 8);
        send_part(16'hABCD, 5);
        compared++;
        if (busy !== 1'b1 || m_valid !== 1'b1) begin
            $display("FAIL rstmid_pre got busy=%b v=%b exp 1 1", busy, m_valid);
            mismatched++;
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if ({m_valid, m_data, word_lost, frame_err, overflow_sticky, busy} !== 21'd0) begin
            $display("FAIL rstmid_async got v=%b d=%h busy=%b exp all 0", m_valid, m_data, busy);
            mismatched++;
        end
        step();
        rst = 1'b0;
        m_ready = 1'b1;
        step();
        send_part(16'hABCD, 8);
        compared++;
        if (m_valid !== 1'b1 || m_data !== 16'hABCD) begin
            $display("FAIL rstmid_after got v=%b d=%h exp 1 abcd", m_valid, m_data);
            mismatched++;
        end
        idle(1);
    endtask

    task automatic test_simul_push_pop();
        int lost0;
        lost0 = lost_pulses;
        m_ready = 1'b0;
        send_part(16'h1234, 8);
        send_part(16'h5A5A, 8);
        send_part(16'hABCD, 7);
        s_in = 2'b01;
        s_valid = 1'b1;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        compared++;
        if (word_lost !== 1'b0 || m_valid !== 1'b1 || m_data !== 16'h5A5A) begin
            $display("FAIL simul_edge got wl=%b v=%b d=%h exp 0 1 5a5a", word_lost, m_valid, m_data);
            mismatched++;
        end
        step();
        compared++;
        if (m_valid !== 1'b1 || m_data !== 16'hABCD) begin
            $display("FAIL simul_newest got v=%b d=%h exp 1 abcd", m_valid, m_data);
            mismatched++;
        end
        step();
        compared++;
        if (m_valid !== 1'b0 || lost_pulses != lost0 || overflow_sticky !== 1'b0) begin
            $display("FAIL simul_done got v=%b lost=%0d st=%b exp 0 0 0",
                     m_valid, lost_pulses - lost0, overflow_sticky);
            mismatched++;
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        lost_pulses = 0;
        frame_pulses = 0;
        test_reset();
        test_reassembly();
        test_back_to_back();
        test_overflow();
        test_gap();
        test_reset_mid();
        test_simul_push_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
